// File: rtl/ps2_receptor.sv
// PS/2 receive stage: synchronise, glitch-filter, deserialise 11-bit frames.
// Optional break-code suppression when PS2_BREAK_FILTER_EN is defined.
module ps2_receptor #(
    parameter int FILTRO  = 8,
    parameter int TIMEOUT = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] dato_out,
    output logic       listo,
    output logic       err_paridad
);

    localparam int FW = $clog2(FILTRO + 1);

    typedef enum logic [2:0] {
        IDLE,
        DATOS,
        PARIDAD,
        PARADA,
        ENTREGA
    } state_t;

    state_t state, state_next;

    logic          clk_s1, clk_s2;
    logic          dat_s1, dat_s2;
    logic          clk_f;
    logic [FW-1:0] cnt_f;
    logic          bajada;
    logic [7:0]    shreg;
    logic [2:0]    bit_cnt;
    logic          par;
    logic [15:0]   to_cnt;
    logic          to_hit;
    logic          frame_ok;
    logic          report;

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    // clk_f only follows after FILTRO consecutive cycles of disagreement
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_f <= '0;
            clk_f <= 1'b1;
        end else if (clk_s2 != clk_f) begin
            if (cnt_f == FW'(FILTRO - 1)) begin
                clk_f <= clk_s2;
                cnt_f <= '0;
            end else begin
                cnt_f <= cnt_f + 1'b1;
            end
        end else begin
            cnt_f <= '0;
        end
    end

    assign bajada   = clk_f & ~clk_s2 & (cnt_f == FW'(FILTRO - 1));
    assign to_hit   = (to_cnt == 16'(TIMEOUT - 1));
    assign frame_ok = dat_s2 & (^{shreg, par});

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bajada && !dat_s2) state_next = DATOS;
            end
            DATOS: begin
                if (bajada) begin
                    if (bit_cnt == 3'd7) state_next = PARIDAD;
                end else if (to_hit) begin
                    state_next = IDLE;
                end
            end
            PARIDAD: begin
                if (bajada)      state_next = PARADA;
                else if (to_hit) state_next = IDLE;
            end
            PARADA: begin
                if (bajada)      state_next = frame_ok ? ENTREGA : IDLE;
                else if (to_hit) state_next = IDLE;
            end
            ENTREGA: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

`ifdef PS2_BREAK_FILTER_EN
    logic brk;

    // F0 arms the flag; the following byte (the released key) is swallowed
    always_ff @(posedge clk) begin
        if (rst) begin
            brk <= 1'b0;
        end else if (state == ENTREGA) begin
            if (brk)                  brk <= 1'b0;
            else if (shreg == 8'hF0) brk <= 1'b1;
        end
    end

    assign report = !brk && (shreg != 8'hF0);
`else
    assign report = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg       <= '0;
            bit_cnt     <= '0;
            par         <= 1'b0;
            to_cnt      <= '0;
            dato_out    <= '0;
            listo       <= 1'b0;
            err_paridad <= 1'b0;
        end else begin
            listo       <= 1'b0;
            err_paridad <= 1'b0;
            if (state == IDLE || state == ENTREGA || bajada)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + 1'b1;
            case (state)
                IDLE: bit_cnt <= '0;
                DATOS: begin
                    if (bajada) begin
                        shreg   <= {dat_s2, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                PARIDAD: begin
                    if (bajada) par <= dat_s2;
                end
                PARADA: begin
                    if (bajada && !frame_ok) err_paridad <= 1'b1;
                end
                ENTREGA: begin
                    dato_out <= shreg;
                    listo    <= report;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_receptor.sv
// Scoreboard bench for ps2_receptor: directed frames, monitor pops expectations.
module tb_ps2_receptor;

    localparam int FILTRO  = 8;
    localparam int TIMEOUT = 2000;
    localparam int H       = 50;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] dato_out;
    logic       listo;
    logic       err_paridad;

    ps2_receptor #(
        .FILTRO (FILTRO),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .dato_out   (dato_out),
        .listo      (listo),
        .err_paridad(err_paridad)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         err;
        logic [7:0] d;
    } ev_t;

    ev_t q[$];
    int  total = 0;
    int  bad = 0;
    int  cyc = 0;
    int  stop_cyc = 0;
    bit  prev_pulse = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // odd parity: p makes the 9-bit popcount odd; bad_par flips it
    task automatic send(input logic [7:0] d, input bit bad_par,
                        input int nbits);
        logic [10:0] f;
        logic        p;
        p = ~(^d) ^ bad_par;
        f = {1'b1, p, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            tick(H);
            ps2_clk = 1'b0;
            if (i == 10) stop_cyc = cyc;
            tick(H);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        tick(4 * H);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (listo || err_paridad) begin
                check("exclusive", {31'd0, listo & err_paridad}, 32'd0);
                check("width", {31'd0, prev_pulse}, 32'd0);
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected: got listo=%0b err=%0b d=%0h want none",
                             listo, err_paridad, dato_out);
                end else begin
                    ev_t e;
                    e = q.pop_front();
                    check("kind", {31'd0, err_paridad}, {31'd0, e.err});
                    check("dato", {24'd0, dato_out}, {24'd0, e.d});
                    if (listo)
                        check("latency",
                              {31'd0, ((cyc - stop_cyc) >= FILTRO + 2) &&
                                      ((cyc - stop_cyc) <= FILTRO + 4)},
                              32'd1);
                end
            end
            prev_pulse = listo | err_paridad;
        end else begin
            prev_pulse = 1'b0;
        end
    end

    initial begin
        rst      = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        tick(3);
        check("rst_dato", {24'd0, dato_out}, 32'h00);
        check("rst_listo", {31'd0, listo}, 32'd0);
        check("rst_err", {31'd0, err_paridad}, 32'd0);
        rst = 1'b0;
        tick(5);

        q.push_back('{1'b0, 8'h3A});
        send(8'h3A, 1'b0, 11);

        q.push_back('{1'b1, 8'h3A});
        send(8'h32, 1'b1, 11);

        q.push_back('{1'b0, 8'h1C});
`ifndef PS2_BREAK_FILTER_EN
        q.push_back('{1'b0, 8'hF0});
        q.push_back('{1'b0, 8'h1C});
`endif
        send(8'h1C, 1'b0, 11);
        send(8'hF0, 1'b0, 11);
        send(8'h1C, 1'b0, 11);

        ps2_data = 1'b0;
        ps2_clk  = 1'b0;
        tick(5);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        tick(20);
        q.push_back('{1'b0, 8'h32});
        send(8'h32, 1'b0, 11);

        send(8'h55, 1'b0, 5);
        tick(TIMEOUT + 10);
        q.push_back('{1'b0, 8'h1C});
        send(8'h1C, 1'b0, 11);

        send(8'h3A, 1'b0, 6);
        rst = 1'b1;
        tick(3);
        check("mid_rst_dato", {24'd0, dato_out}, 32'h00);
        check("mid_rst_listo", {31'd0, listo}, 32'd0);
        check("mid_rst_err", {31'd0, err_paridad}, 32'd0);
        rst = 1'b0;
        tick(5);
        q.push_back('{1'b0, 8'h1C});
        send(8'h1C, 1'b0, 11);

        for (int i = 0; i < 100 && q.size() != 0; i++) tick(1);
        check("drained", q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
